dmem_arbiter: RTL and testbench

- Shares the single data RAM port between two requesters: the core MEM stage and a debug/loader port (program load, memory inspection, display readback).
- Core has fixed priority. A starvation counter forces a one-cycle debug grant, during which the core is stalled.
- Tracks which requester owns each in-flight read and returns the read data to that requester.
- Sits between the EX_MEM pipeline register outputs and the DRAM instance.

---
 rtl/dmem_arbiter_if.sv | 58 +++++
 rtl/dmem_arbiter.sv | 83 ++++++++
 tb/tb_dmem_arbiter.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Signal bundle between the data-memory arbiter, its two requesters and the DRAM port.
// The slave modport is the arbiter's view; master is the surrounding environment's view.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    // Core MEM-stage side
    logic              core_req;
    logic              core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic [2:0]        core_func3;
    logic              core_stall;
    logic [DATA_W-1:0] core_rdata;
    logic              core_rvalid;

    // Debug / loader side
    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_gnt;
    logic [DATA_W-1:0] dbg_rdata;
    logic              dbg_rvalid;

    // DRAM side
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wren;
    logic [2:0]        mem_func3;
    logic [DATA_W-1:0] mem_rdata;

    // Observability of the starvation counter
    logic [3:0]        starve_cnt;

    // Handshake: a request is held high until served. dbg_gnt / ~core_stall mark the
    // cycle the access is issued; writes land at the closing edge of that cycle, and
    // read data is returned one cycle later, qualified by the requester's rvalid.
    modport slave (
        input  core_req, core_we, core_addr, core_wdata, core_func3,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  mem_rdata,
        output core_stall, core_rdata, core_rvalid,
        output dbg_gnt, dbg_rdata, dbg_rvalid,
        output mem_addr, mem_wdata, mem_wren, mem_func3,
        output starve_cnt
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata, core_func3,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output mem_rdata,
        input  core_stall, core_rdata, core_rvalid,
        input  dbg_gnt, dbg_rdata, dbg_rvalid,
        input  mem_addr, mem_wdata, mem_wren, mem_func3,
        input  starve_cnt
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares the single DRAM port between the core MEM stage (fixed priority) and a debug/loader
// port, with a starvation counter that forces an occasional one-cycle debug grant.
module dmem_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic           clock,
    input  logic           clear,
    dmem_arbiter_if.slave  bus
);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [2:0] FUNC3_WORD = 3'b010;

    logic [3:0]        starve_cnt;
    logic [3:0]        starve_nxt;
    logic              rd_core;
    logic              rd_dbg;
    logic              force_gnt;
    logic              dbg_gnt;
    logic              core_gnt;
    logic [ADDR_W-1:0] addr_mux;
    logic [DATA_W-1:0] wdata_mux;
    logic [2:0]        func3_mux;
    logic              wren_mux;

    // Grants are gated by clear so nothing reaches the DRAM while in reset.
    always_comb begin
        force_gnt = bus.dbg_req && (starve_cnt == STARVE_LIM);
        dbg_gnt   = clear && bus.dbg_req && (!bus.core_req || force_gnt);
        core_gnt  = clear && bus.core_req && !dbg_gnt;
    end

    always_comb begin
        addr_mux  = bus.core_addr;
        wdata_mux = bus.core_wdata;
        func3_mux = bus.core_func3;
        wren_mux  = 1'b0;
        if (dbg_gnt) begin
            addr_mux  = bus.dbg_addr;
            wdata_mux = bus.dbg_wdata;
            func3_mux = FUNC3_WORD;
            wren_mux  = bus.dbg_we;
        end else if (core_gnt) begin
            wren_mux  = bus.core_we;
        end
    end

    // Counts consecutive denied debug cycles; saturates so the force term stays asserted.
    always_comb begin
        starve_nxt = starve_cnt;
        if (!bus.dbg_req || dbg_gnt) begin
            starve_nxt = 4'd0;
        end else if (starve_cnt != STARVE_LIM) begin
            starve_nxt = starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            starve_cnt <= 4'd0;
            rd_core    <= 1'b0;
            rd_dbg     <= 1'b0;
        end else begin
            starve_cnt <= starve_nxt;
            rd_core    <= core_gnt && !bus.core_we;
            rd_dbg     <= dbg_gnt && !bus.dbg_we;
        end
    end

    assign bus.core_stall  = bus.core_req && dbg_gnt;
    assign bus.dbg_gnt     = dbg_gnt;
    assign bus.mem_addr    = addr_mux;
    assign bus.mem_wdata   = wdata_mux;
    assign bus.mem_func3   = func3_mux;
    assign bus.mem_wren    = wren_mux;
    // Only one requester is granted per cycle, so the two rvalids never overlap.
    assign bus.core_rvalid = rd_core;
    assign bus.dbg_rvalid  = rd_dbg;
    assign bus.core_rdata  = bus.mem_rdata;
    assign bus.dbg_rdata   = bus.mem_rdata;
    assign bus.starve_cnt  = starve_cnt;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: cycle-level grant checks plus a read-return scoreboard.
module tb_dmem_arbiter;
    logic clock = 1'b0;
    logic clear = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] core_exp_q[$];
    logic [31:0] dbg_exp_q[$];
    logic [31:0] dram[256];

    dmem_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus();

    dmem_arbiter #(.ADDR_W(8), .DATA_W(32), .STARVE_MAX(4)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // DRAM model: synchronous write, read data one cycle after the address.
    always @(posedge clock) begin
        if (bus.mem_wren === 1'b1) dram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= dram[bus.mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Read-return monitor
    always @(negedge clock) begin
        if (bus.core_rvalid === 1'b1 && bus.dbg_rvalid === 1'b1) begin
            check("rvalid_exclusive", 32'd1, 32'd0);
        end
        if (bus.core_rvalid === 1'b1) begin
            if (core_exp_q.size() == 0) check("core_rvalid_unexpected", 32'd1, 32'd0);
            else check("core_rdata", bus.core_rdata, core_exp_q.pop_front());
        end
        if (bus.dbg_rvalid === 1'b1) begin
            if (dbg_exp_q.size() == 0) check("dbg_rvalid_unexpected", 32'd1, 32'd0);
            else check("dbg_rdata", bus.dbg_rdata, dbg_exp_q.pop_front());
        end
    end

    task automatic drive(input logic cr, input logic cw, input logic [7:0] ca,
                         input logic [31:0] cd, input logic [2:0] cf,
                         input logic dr, input logic dw, input logic [7:0] da,
                         input logic [31:0] dd);
        bus.core_req   = cr;
        bus.core_we    = cw;
        bus.core_addr  = ca;
        bus.core_wdata = cd;
        bus.core_func3 = cf;
        bus.dbg_req    = dr;
        bus.dbg_we     = dw;
        bus.dbg_addr   = da;
        bus.dbg_wdata  = dd;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 8'h00, 32'h0, 3'b010, 1'b0, 1'b0, 8'h00, 32'h0);
    endtask

    // Checks combinational grant outputs mid-cycle, then advances to just after the next edge.
    task automatic step(input string name, input logic eg, input logic es, input logic ew);
        @(negedge clock);
        check({name, "_dbg_gnt"}, 32'(bus.dbg_gnt), 32'(eg));
        check({name, "_core_stall"}, 32'(bus.core_stall), 32'(es));
        check({name, "_mem_wren"}, 32'(bus.mem_wren), 32'(ew));
        @(posedge clock);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) dram[i] = 32'h0;
        dram[8'h20] = 32'h1234_5678;
        dram[8'h24] = 32'hA5A5_0024;
        clear = 1'b0;
        drive(1'b1, 1'b1, 8'h20, 32'hBAD0_0001, 3'b010, 1'b1, 1'b1, 8'h24, 32'hBAD0_0002);
        @(posedge clock);
        #1;

        // Reset held for two cycles with both requesters asserting writes
        step("rst0", 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        check("rst_core_rvalid", 32'(bus.core_rvalid), 32'd0);
        check("rst_dbg_rvalid", 32'(bus.dbg_rvalid), 32'd0);
        @(posedge clock);
        #1;

        // Release: core load wins the first cycle
        clear = 1'b1;
        drive(1'b1, 1'b0, 8'h20, 32'h0, 3'b010, 1'b1, 1'b0, 8'h24, 32'h0);
        check("rel_starve_cnt", 32'(bus.starve_cnt), 32'd0);
        core_exp_q.push_back(32'h1234_5678);
        step("release", 1'b0, 1'b0, 1'b0);

        // Idle-core debug write then read (back-to-back debug grants)
        drive(1'b0, 1'b0, 8'h00, 32'h0, 3'b010, 1'b1, 1'b1, 8'h10, 32'hDEAD_BEEF);
        step("dbg_wr", 1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 8'h00, 32'h0, 3'b010, 1'b1, 1'b0, 8'h10, 32'h0);
        dbg_exp_q.push_back(32'hDEAD_BEEF);
        step("dbg_rd", 1'b1, 1'b0, 1'b0);
        idle();
        step("idle0", 1'b0, 1'b0, 1'b0);

        // Starvation under continuous core loads: forced grants in cycles 4 and 9
        for (int c = 0; c < 10; c++) begin
            drive(1'b1, 1'b0, 8'h20, 32'h0, 3'b010, 1'b1, 1'b0, 8'h24, 32'h0);
            if (c == 4 || c == 9) begin
                dbg_exp_q.push_back(32'hA5A5_0024);
                step($sformatf("starve%0d", c), 1'b1, 1'b1, 1'b0);
            end else begin
                core_exp_q.push_back(32'h1234_5678);
                step($sformatf("starve%0d", c), 1'b0, 1'b0, 1'b0);
            end
        end
        idle();
        step("idle1", 1'b0, 1'b0, 1'b0);

        // Withdrawal against core stores: dbg_req drops in cycle 3, forced grant in cycle 8
        for (int c = 0; c < 9; c++) begin
            drive(1'b1, 1'b1, 8'(8'h30 + c), 32'(c), 3'b000,
                  (c != 3), 1'b0, 8'h24, 32'h0);
            if (c == 4) check("wd_starve_cnt", 32'(bus.starve_cnt), 32'd0);
            #1;
            if (c == 8) begin
                check("wd_mem_addr", 32'(bus.mem_addr), 32'h24);
                check("wd_mem_func3", 32'(bus.mem_func3), 32'd2);
                dbg_exp_q.push_back(32'hA5A5_0024);
                step($sformatf("wd%0d", c), 1'b1, 1'b1, 1'b0);
            end else begin
                check("wd_mem_addr", 32'(bus.mem_addr), 32'(8'h30 + c));
                check("wd_mem_wdata", bus.mem_wdata, 32'(c));
                step($sformatf("wd%0d", c), 1'b0, 1'b0, 1'b1);
            end
        end

        // Stored word readback by core; stalled store must not have landed
        drive(1'b1, 1'b0, 8'h32, 32'h0, 3'b010, 1'b0, 1'b0, 8'h00, 32'h0);
        core_exp_q.push_back(32'd2);
        step("core_rd32", 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 32'h0, 3'b010, 1'b1, 1'b0, 8'h38, 32'h0);
        dbg_exp_q.push_back(32'd0);
        step("dbg_rd38", 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 32'h0, 3'b010, 1'b1, 1'b0, 8'h10, 32'h0);
        dbg_exp_q.push_back(32'hDEAD_BEEF);
        step("dbg_rd10", 1'b1, 1'b0, 1'b0);

        // Reset mid-operation: contention builds the counter, then a read under clear
        for (int c = 0; c < 2; c++) begin
            drive(1'b1, 1'b0, 8'h20, 32'h0, 3'b010, 1'b1, 1'b0, 8'h24, 32'h0);
            core_exp_q.push_back(32'h1234_5678);
            step("pre_rst", 1'b0, 1'b0, 1'b0);
        end
        clear = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 32'h0, 3'b010, 1'b1, 1'b1, 8'h24, 32'hBAD0_0003);
        step("mid_rst", 1'b0, 1'b0, 1'b0);
        clear = 1'b1;
        idle();
        check("post_rst_starve_cnt", 32'(bus.starve_cnt), 32'd0);
        @(negedge clock);
        check("post_rst_dbg_rvalid", 32'(bus.dbg_rvalid), 32'd0);
        check("post_rst_core_rvalid", 32'(bus.core_rvalid), 32'd0);
        @(posedge clock);
        #1;
        check("post_rst_dram24", dram[8'h24], 32'hA5A5_0024);

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("core_q_drained", 32'(core_exp_q.size()), 32'd0);
        check("dbg_q_drained", 32'(dbg_exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
